bp_fe_fetch_replay_buffer: RTL



---
 rtl/bp_fe_fetch_replay_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bp_fe_fetch_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bp_fe_fetch_replay_buffer
// Description : Front-end fetch buffer. I$ hits are queued in a FWFT FIFO for
//               the downstream consumer. An I$ miss is turned into a single
//               replay request, and later responses are dropped until the fill
//               for the replayed address arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_fe_fetch_replay_buffer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          flush_i,

    input  logic                          icache_v_i,
    input  logic [vaddr_width_p-1:0]      icache_vaddr_i,
    input  logic [instr_width_p-1:0]      icache_data_i,
    input  logic                          icache_miss_not_data_i,
    output logic                          icache_ready_o,

    output logic                          replay_v_o,
    output logic [vaddr_width_p-1:0]      replay_vaddr_o,
    input  logic                          replay_ready_i,

    output logic                          fetch_v_o,
    output logic [vaddr_width_p-1:0]      fetch_vaddr_o,
    output logic [instr_width_p-1:0]      fetch_instr_o,
    input  logic                          fetch_yumi_i,

    output logic [$clog2(els_p):0]        count_o
);

    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ELS = CNT_W'(els_p);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e                   state, state_n;
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         count;
    logic [vaddr_width_p-1:0] replay_vaddr;
    logic [vaddr_width_p-1:0] mem_vaddr [els_p];
    logic [instr_width_p-1:0] mem_instr [els_p];

    logic full;
    logic accept;
    logic match;
    logic enq;
    logic deq;
    logic capture;

    // Acceptance, FIFO push/pop decisions and replay state transitions.
    always_comb begin
        full           = (count == ELS);
        icache_ready_o = ((state == RUN) && !full) || (state == WAIT);
        accept         = icache_v_i && icache_ready_o;
        match          = (icache_vaddr_i == replay_vaddr);
        deq            = fetch_yumi_i && (count != '0);
        state_n        = state;
        enq            = 1'b0;
        capture        = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (icache_miss_not_data_i) begin
                        capture = 1'b1;
                        state_n = SEND;
                    end else begin
                        // Acceptance in RUN already implies not-full.
                        enq = 1'b1;
                    end
                end
            end
            SEND: begin
                if (replay_ready_i) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Only the response for the replayed address matters here.
                if (accept && match) begin
                    if (icache_miss_not_data_i) begin
                        capture = 1'b1;
                        state_n = SEND;
                    end else if (full) begin
                        // No room for the fill: ask for it again.
                        state_n = SEND;
                    end else begin
                        enq     = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            default: state_n = RUN;
        endcase
    end

    // Control state: flush wins over every other update.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            replay_vaddr <= '0;
        end else if (flush_i) begin
            state  <= RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                replay_vaddr <= icache_vaddr_i;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (enq && !flush_i) begin
            mem_vaddr[wr_ptr] <= icache_vaddr_i;
            mem_instr[wr_ptr] <= icache_data_i;
        end
    end

    assign fetch_v_o      = (count != '0);
    assign fetch_vaddr_o  = mem_vaddr[rd_ptr];
    assign fetch_instr_o  = mem_instr[rd_ptr];
    assign replay_v_o     = (state == SEND);
    assign replay_vaddr_o = replay_vaddr;
    assign count_o        = count;

endmodule
`default_nettype wire
